// File: rtl/tmds_stream_encoder.sv
// Purpose: NUM_CH-lane TMDS 8b/10b encoder (video / control / guard) with per-lane running disparity.
// Latency: 2 cycles from acceptance (S0 capture -> S1 q_m -> S2 symbol + disparity).
// Backpressure: all stages stall together while out_valid & ~out_ready; in_ready = ~stall.
// Ports:
//   clk, n_rst            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_mode 00 ctrl, 01 video, 10 guard, 11 ctrl
//   in_pixel/ctrl/guard   per-lane byte, {C1,C0}, raw 10-bit guard word
//   out_valid/out_ready   output handshake; out_data symbol per lane (bit 0 first)
//   out_disp              per-lane signed running disparity after last committed symbol
module tmds_stream_encoder #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_mode,
  input  logic [8*NUM_CH-1:0]       in_pixel,
  input  logic [2*NUM_CH-1:0]       in_ctrl,
  input  logic [10*NUM_CH-1:0]      in_guard,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [10*NUM_CH-1:0]      out_data,
  output logic [CNT_W*NUM_CH-1:0]   out_disp
);

  localparam logic [1:0] MODE_VIDEO = 2'b01;
  localparam logic [1:0] MODE_GUARD = 2'b10;

  logic                      adv;

  logic                      s0_vld;
  logic [1:0]                s0_mode;
  logic [8*NUM_CH-1:0]       s0_pixel;
  logic [2*NUM_CH-1:0]       s0_ctrl;
  logic [10*NUM_CH-1:0]      s0_guard;

  logic                      s1_vld;
  logic [1:0]                s1_mode;
  logic [9*NUM_CH-1:0]       s1_qm;
  logic [2*NUM_CH-1:0]       s1_ctrl;
  logic [10*NUM_CH-1:0]      s1_guard;

  logic [9*NUM_CH-1:0]       qm_nxt;
  logic [10*NUM_CH-1:0]      sym_nxt;
  logic [CNT_W*NUM_CH-1:0]   cnt_nxt;

  // A full output register that is not being taken freezes the whole pipe.
  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    // ---------------- stage 1: transition minimisation ----------------
    logic [7:0] d;
    logic [3:0] n1_d;
    logic [8:0] qm;

    assign d = s0_pixel[8*g +: 8];

    always_comb begin
      n1_d = '0;
      for (int i = 0; i < 8; i++) n1_d = n1_d + 4'(d[i]);
      qm    = '0;
      qm[0] = d[0];
      if (n1_d > 4'd4 || (n1_d == 4'd4 && !d[0])) begin
        for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
        qm[8] = 1'b0;
      end else begin
        for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
        qm[8] = 1'b1;
      end
    end

    assign qm_nxt[9*g +: 9] = qm;

    // ---------------- stage 2: DC balance / mode select ----------------
    logic [8:0]              q;
    logic [1:0]              ctrl;
    logic [3:0]              n1;
    logic [3:0]              n0;
    logic signed [CNT_W-1:0] c;
    logic signed [CNT_W-1:0] diff;     // n1 - n0
    logic signed [CNT_W-1:0] two_q8;   // 2*q_m[8]
    logic signed [CNT_W-1:0] two_nq8;  // 2*~q_m[8]
    logic signed [CNT_W-1:0] c_nx;
    logic [9:0]              sym;

    assign q    = s1_qm[9*g +: 9];
    assign ctrl = s1_ctrl[2*g +: 2];
    assign c    = out_disp[CNT_W*g +: CNT_W];

    always_comb begin
      n1 = '0;
      for (int i = 0; i < 8; i++) n1 = n1 + 4'(q[i]);
      n0      = 4'd8 - n1;
      diff    = $signed({{(CNT_W-4){1'b0}}, n1}) - $signed({{(CNT_W-4){1'b0}}, n0});
      two_q8  = q[8] ? CNT_W'(2) : '0;
      two_nq8 = q[8] ? '0 : CNT_W'(2);
      sym     = s1_guard[10*g +: 10];
      c_nx    = c;
      case (s1_mode)
        MODE_VIDEO: begin
          if (c == '0 || n1 == n0) begin
            sym  = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            c_nx = q[8] ? c + diff : c - diff;
          end else if ((!c[CNT_W-1] && n1 > n0) || (c[CNT_W-1] && n0 > n1)) begin
            // c is nonzero here, so the sign bit alone separates c > 0 from c < 0.
            sym  = {1'b1, q[8], ~q[7:0]};
            c_nx = c + two_q8 - diff;
          end else begin
            sym  = {1'b0, q[8], q[7:0]};
            c_nx = c - two_nq8 + diff;
          end
        end
        MODE_GUARD: begin
          sym  = s1_guard[10*g +: 10];
          c_nx = c;
        end
        default: begin
          c_nx = '0;
          case (ctrl)
            2'b00:   sym = 10'h354;
            2'b01:   sym = 10'h0AB;
            2'b10:   sym = 10'h154;
            default: sym = 10'h2AB;
          endcase
        end
      endcase
    end

    assign sym_nxt[10*g +: 10]       = sym;
    assign cnt_nxt[CNT_W*g +: CNT_W] = c_nx;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s0_vld    <= 1'b0;
      s0_mode   <= '0;
      s0_pixel  <= '0;
      s0_ctrl   <= '0;
      s0_guard  <= '0;
      s1_vld    <= 1'b0;
      s1_mode   <= '0;
      s1_qm     <= '0;
      s1_ctrl   <= '0;
      s1_guard  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_disp  <= '0;
    end else if (adv) begin
      s0_vld    <= in_valid;
      s0_mode   <= in_mode;
      s0_pixel  <= in_pixel;
      s0_ctrl   <= in_ctrl;
      s0_guard  <= in_guard;
      s1_vld    <= s0_vld;
      s1_mode   <= s0_mode;
      s1_qm     <= qm_nxt;
      s1_ctrl   <= s0_ctrl;
      s1_guard  <= s0_guard;
      out_valid <= s1_vld;
      // Bubbles leave both the last symbol and the disparity untouched.
      if (s1_vld) begin
        out_data <= sym_nxt;
        out_disp <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tmds_stream_encoder.sv
// Purpose: directed bench for tmds_stream_encoder with hand-computed expected symbols.
// Latency: beats collected by an output monitor and compared in order of arrival.
// Backpressure: out_ready driven by the bench to exercise stalls.
module tb_tmds_stream_encoder;

  logic        clk;
  logic        n_rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [23:0] in_pixel;
  logic [5:0]  in_ctrl;
  logic [29:0] in_guard;
  logic        out_ready;
  logic        out_valid;
  logic [29:0] out_data;
  logic [14:0] out_disp;

  int errors = 0;
  int checks = 0;

  logic [29:0] q_data[$];
  logic [14:0] q_disp[$];

  tmds_stream_encoder #(.NUM_CH(3), .CNT_W(5)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_pixel  (in_pixel),
    .in_ctrl   (in_ctrl),
    .in_guard  (in_guard),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_disp  (out_disp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Record every symbol set actually handed downstream on the coming edge.
  always @(negedge clk) begin
    if (n_rst && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_disp.push_back(out_disp);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] mode, input logic [7:0] pix0, input logic [7:0] pix1,
                      input logic [7:0] pix2, input logic [1:0] ctrl, input logic [9:0] guard);
    int n = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_pixel = {pix2, pix1, pix0};
    in_ctrl  = {3{ctrl}};
    in_guard = {3{guard}};
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input bit full, input logic [29:0] exp_d,
                             input logic [14:0] exp_p);
    int n = 0;
    logic [29:0] d;
    logic [14:0] p;
    while (q_data.size() == 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q_data.size() == 0) begin
      check_eq({tag, "_timeout"}, q_data.size(), 32'd1);
      return;
    end
    d = q_data.pop_front();
    p = q_disp.pop_front();
    if (full) begin
      check_eq({tag, "_dat"}, {2'b0, d}, {2'b0, exp_d});
      check_eq({tag, "_disp"}, {17'b0, p}, {17'b0, exp_p});
    end else begin
      check_eq({tag, "_dat"}, {22'b0, d[9:0]}, {22'b0, exp_d[9:0]});
      check_eq({tag, "_disp"}, {27'b0, p[4:0]}, {27'b0, exp_p[4:0]});
    end
  endtask

  initial begin
    n_rst     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_pixel  = '0;
    in_ctrl   = '0;
    in_guard  = '0;
    out_ready = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_data", {2'b0, out_data}, 32'd0);
    check_eq("rst_out_disp", {17'b0, out_disp}, 32'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    #1;
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: video 0x00 x3 from a control start
    send(2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 10'h0);
    send(2'b01, 8'h00, 8'h00, 8'h00, 2'b00, 10'h0);
    send(2'b01, 8'h00, 8'h00, 8'h00, 2'b00, 10'h0);
    send(2'b01, 8'h00, 8'h00, 8'h00, 2'b00, 10'h0);
    expect_beat("t1_ctl", 1'b0, 30'h354, 15'h00);
    expect_beat("t1_v0", 1'b0, 30'h100, 15'h18);
    expect_beat("t1_v1", 1'b0, 30'h3FF, 15'h02);
    expect_beat("t1_v2", 1'b0, 30'h100, 15'h1A);

    // 2: control symbols, cnt cleared from -6; mode 11 also treated as control
    send(2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 10'h0);
    send(2'b00, 8'h00, 8'h00, 8'h00, 2'b01, 10'h0);
    send(2'b11, 8'h00, 8'h00, 8'h00, 2'b10, 10'h0);
    send(2'b00, 8'h00, 8'h00, 8'h00, 2'b11, 10'h0);
    expect_beat("t2_c00", 1'b1, {3{10'h354}}, 15'h0);
    expect_beat("t2_c01", 1'b1, {3{10'h0AB}}, 15'h0);
    expect_beat("t2_c10", 1'b1, {3{10'h154}}, 15'h0);
    expect_beat("t2_c11", 1'b1, {3{10'h2AB}}, 15'h0);

    // 3: video 0xFF, guard 0x2CC, video 0x00
    send(2'b01, 8'hFF, 8'hFF, 8'hFF, 2'b00, 10'h0);
    send(2'b10, 8'h00, 8'h00, 8'h00, 2'b00, 10'h2CC);
    send(2'b01, 8'h00, 8'h00, 8'h00, 2'b00, 10'h0);
    expect_beat("t3_vff", 1'b0, 30'h200, 15'h18);
    expect_beat("t3_grd", 1'b0, 30'h2CC, 15'h18);
    expect_beat("t3_v00", 1'b0, 30'h3FF, 15'h02);

    // 4: stall with three beats in flight
    send(2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 10'h0);
    expect_beat("t4_ctl", 1'b0, 30'h354, 15'h00);
    out_ready = 1'b0;
    send(2'b01, 8'h00, 8'h00, 8'h00, 2'b00, 10'h0);
    send(2'b01, 8'h00, 8'h00, 8'h00, 2'b00, 10'h0);
    send(2'b01, 8'h00, 8'h00, 8'h00, 2'b00, 10'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("t4_in_ready", {31'b0, in_ready}, 32'd0);
      check_eq("t4_out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("t4_hold_dat", {22'b0, out_data[9:0]}, 32'h100);
      check_eq("t4_hold_disp", {27'b0, out_disp[4:0]}, 32'h18);
    end
    check_eq("t4_no_xfer", q_data.size(), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    expect_beat("t4_b0", 1'b0, 30'h100, 15'h18);
    expect_beat("t4_b1", 1'b0, 30'h3FF, 15'h02);
    expect_beat("t4_b2", 1'b0, 30'h100, 15'h1A);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t4_no_dup", q_data.size(), 32'd0);

    // 5: reset mid-stream (lane cnt is -6 beforehand)
    send(2'b01, 8'hFF, 8'hFF, 8'hFF, 2'b00, 10'h0);
    send(2'b01, 8'hFF, 8'hFF, 8'hFF, 2'b00, 10'h0);
    n_rst = 1'b0;
    #1;
    check_eq("t5_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("t5_out_disp", {17'b0, out_disp}, 32'd0);
    check_eq("t5_out_data", {2'b0, out_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_dropped", q_data.size(), 32'd0);
    send(2'b01, 8'h00, 8'h00, 8'h00, 2'b00, 10'h0);
    expect_beat("t5_first", 1'b0, 30'h100, 15'h18);

    // 6: distinct bytes per lane with bubbles in between
    send(2'b00, 8'h00, 8'h00, 8'h00, 2'b00, 10'h0);
    expect_beat("t6_ctl", 1'b1, {3{10'h354}}, 15'h0);
    send(2'b01, 8'h10, 8'hA5, 8'hF0, 2'b00, 10'h0);
    @(posedge clk);
    #1;
    send(2'b01, 8'h10, 8'hA5, 8'hF0, 2'b00, 10'h0);
    repeat (2) @(posedge clk);
    #1;
    send(2'b01, 8'h10, 8'hA5, 8'hF0, 2'b00, 10'h0);
    send(2'b01, 8'h10, 8'hA5, 8'hF0, 2'b00, 10'h0);
    expect_beat("t6_b0", 1'b1, {10'h205, 10'h163, 10'h1F0}, {5'h1C, 5'h00, 5'h00});
    expect_beat("t6_b1", 1'b1, {10'h0FA, 10'h163, 10'h1F0}, {5'h1E, 5'h00, 5'h00});
    expect_beat("t6_b2", 1'b1, {10'h0FA, 10'h163, 10'h1F0}, {5'h00, 5'h00, 5'h00});
    expect_beat("t6_b3", 1'b1, {10'h205, 10'h163, 10'h1F0}, {5'h1C, 5'h00, 5'h00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
